// File: rtl/score_display_ctrl_pkg.sv
// Shared display codes and FSM encodings for the score/display controller.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package score_defs;

    localparam logic [3:0] CODE_DASH = 4'd11;
    localparam logic [3:0] CODE_O    = 4'd12;
    localparam logic [3:0] CODE_V    = 4'd13;
    localparam logic [3:0] CODE_E    = 4'd14;
    localparam logic [3:0] CODE_R    = 4'd15;

    typedef enum logic [0:0] {
        ADD_IDLE = 1'b0,
        ADD_RUN  = 1'b1
    } add_state_t;

    // GO_HI is only reachable when the high-score page is built in.
    typedef enum logic [1:0] {
        DISP_PLAY     = 2'd0,
        DISP_GO_OVER  = 2'd1,
        DISP_GO_SCORE = 2'd2,
        DISP_GO_HI    = 2'd3
    } disp_state_t;

    function automatic logic [3:0] clamp_bcd(input logic [3:0] n);
        return (n > 4'd9) ? 4'd9 : n;
    endfunction

endpackage

// File: rtl/score_display_ctrl_bcd_digit_add.sv
// Single BCD digit adder with carry in/out.
// Latency: combinational.
// Backpressure: none.
module bcd_digit_add (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);

    logic [4:0] raw;

    always_comb begin
        raw  = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
        cout = (raw > 5'd9);
        // raw - 10 and raw + 6 agree modulo 16
        sum  = cout ? (raw[3:0] + 4'd6) : raw[3:0];
    end

endmodule

// File: rtl/score_display_ctrl.sv
// BCD score keeper and seven-segment page selector; HIGH_SCORE_EN adds a high-score page.
// Latency: award commits 4 cycles after handshake; display follows inputs by 1 cycle.
// Backpressure: add_ready low while an award is being summed or game_over is high.
module score_display_ctrl
    import score_defs::*;
#(
    parameter int ALT_CYCLES = 50_000_000,
    parameter int CNT_W      = 26
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       new_game,
    input  logic       game_over,
    input  logic       add_valid,
    input  logic [7:0] add_pts,
    output logic       add_ready,
    output logic [3:0] score_1,
    output logic [3:0] score_2,
    output logic [3:0] score_3,
    output logic [3:0] score_4
);

    localparam logic [CNT_W-1:0] TMR_LAST = CNT_W'(ALT_CYCLES - 1);

    add_state_t       add_q, add_d;
    disp_state_t      disp_q, disp_d;
    logic [1:0]       k_q;
    logic             carry_q;
    logic [7:0]       pts_q;
    logic [11:0]      work_q;
    logic [15:0]      score_q, score_d;
    logic [CNT_W-1:0] tmr_q, tmr_d;
    logic             hs;
    logic             ready_d;
    logic [3:0]       a_dig, b_dig, dsum;
    logic             dcout;
    logic [15:0]      disp_val;

`ifdef HIGH_SCORE_EN
    logic [15:0] hi_q, hi_d;
    logic        go_prev_q, hi_pend_q, hi_pend_d;
    logic        go_rise, hi_upd;
`endif

    assign hs = add_valid & add_ready;

    always_comb begin
        a_dig = 4'd0;
        b_dig = 4'd0;
        case (k_q)
            2'd0: begin a_dig = score_q[3:0];   b_dig = pts_q[3:0]; end
            2'd1: begin a_dig = score_q[7:4];   b_dig = pts_q[7:4]; end
            2'd2: begin a_dig = score_q[11:8];  end
            default: begin a_dig = score_q[15:12]; end
        endcase
    end

    bcd_digit_add u_digit_add (
        .a    (a_dig),
        .b    (b_dig),
        .cin  (carry_q),
        .sum  (dsum),
        .cout (dcout)
    );

    // Add FSM: the score register only changes on the final digit, never mid-sum.
    always_comb begin
        add_d   = add_q;
        score_d = score_q;
        case (add_q)
            ADD_IDLE: if (hs) add_d = ADD_RUN;
            ADD_RUN: begin
                if (k_q == 2'd3) begin
                    add_d   = ADD_IDLE;
                    score_d = dcout ? 16'h9999 : {dsum, work_q};
                end
            end
            default: add_d = ADD_IDLE;
        endcase
        if (new_game) begin
            add_d   = ADD_IDLE;
            score_d = '0;
        end
        ready_d = (add_d == ADD_IDLE) && !game_over;
    end

`ifdef HIGH_SCORE_EN
    // A rise during an add waits until the FSM is idle, i.e. after the commit.
    always_comb begin
        go_rise   = game_over & ~go_prev_q;
        hi_upd    = (go_rise | hi_pend_q) && (add_q == ADD_IDLE);
        hi_d      = hi_q;
        hi_pend_d = (go_rise | hi_pend_q) & ~hi_upd;
        if (new_game) begin
            hi_pend_d = 1'b0;
        end else if (hi_upd && (score_q > hi_q)) begin
            hi_d = score_q;
        end
    end
`endif

    always_comb begin
        disp_d = disp_q;
        tmr_d  = tmr_q;
        case (disp_q)
            DISP_PLAY: begin
                tmr_d = '0;
                if (game_over) disp_d = DISP_GO_OVER;
            end
            default: begin
                if (!game_over) begin
                    disp_d = DISP_PLAY;
                    tmr_d  = '0;
                end else if (tmr_q == TMR_LAST) begin
                    tmr_d = '0;
                    case (disp_q)
                        DISP_GO_OVER: disp_d = DISP_GO_SCORE;
`ifdef HIGH_SCORE_EN
                        DISP_GO_SCORE: disp_d = DISP_GO_HI;
`endif
                        default: disp_d = DISP_GO_OVER;
                    endcase
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
        endcase
        if (new_game) begin
            disp_d = DISP_PLAY;
            tmr_d  = '0;
        end
    end

    always_comb begin
        case (disp_d)
            DISP_GO_OVER: disp_val = {CODE_O, CODE_V, CODE_E, CODE_R};
`ifdef HIGH_SCORE_EN
            DISP_GO_HI: disp_val = {(hi_d[15:12] == 4'd0) ? CODE_DASH : hi_d[15:12], hi_d[11:0]};
`endif
            default: disp_val = score_d;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            add_q     <= ADD_IDLE;
            disp_q    <= DISP_PLAY;
            score_q   <= '0;
            tmr_q     <= '0;
            add_ready <= 1'b0;
            score_4   <= 4'd0;
            score_3   <= 4'd0;
            score_2   <= 4'd0;
            score_1   <= 4'd0;
        end else begin
            add_q     <= add_d;
            disp_q    <= disp_d;
            score_q   <= score_d;
            tmr_q     <= tmr_d;
            add_ready <= ready_d;
            score_4   <= disp_val[15:12];
            score_3   <= disp_val[11:8];
            score_2   <= disp_val[7:4];
            score_1   <= disp_val[3:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            k_q     <= 2'd0;
            carry_q <= 1'b0;
            pts_q   <= '0;
            work_q  <= '0;
        end else if (add_q == ADD_IDLE) begin
            if (hs) begin
                pts_q   <= {clamp_bcd(add_pts[7:4]), clamp_bcd(add_pts[3:0])};
                k_q     <= 2'd0;
                carry_q <= 1'b0;
            end
        end else begin
            case (k_q)
                2'd0: work_q[3:0]  <= dsum;
                2'd1: work_q[7:4]  <= dsum;
                2'd2: work_q[11:8] <= dsum;
                default: ;
            endcase
            carry_q <= dcout;
            k_q     <= k_q + 2'd1;
        end
    end

`ifdef HIGH_SCORE_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            hi_q      <= '0;
            hi_pend_q <= 1'b0;
            go_prev_q <= 1'b0;
        end else begin
            hi_q      <= hi_d;
            hi_pend_q <= hi_pend_d;
            go_prev_q <= game_over;
        end
    end
`endif

endmodule

// File: tb/tb_score_display_ctrl.sv
// Randomised scoreboard bench for score_display_ctrl against an integer-arithmetic reference model.
module tb_score_display_ctrl;

    localparam int ALT = 4;
`ifdef HIGH_SCORE_EN
    localparam int NPAGES = 3;
`else
    localparam int NPAGES = 2;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       new_game = 1'b0;
    logic       game_over = 1'b0;
    logic       add_valid = 1'b0;
    logic [7:0] add_pts = 8'h00;
    logic       add_ready;
    logic [3:0] score_1, score_2, score_3, score_4;

    always #5 clk = ~clk;

    score_display_ctrl #(.ALT_CYCLES(ALT), .CNT_W(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .new_game  (new_game),
        .game_over (game_over),
        .add_valid (add_valid),
        .add_pts   (add_pts),
        .add_ready (add_ready),
        .score_1   (score_1),
        .score_2   (score_2),
        .score_3   (score_3),
        .score_4   (score_4)
    );

    // Reference model: decimal integers and a cycle countdown per award.
    int  m_score = 0, m_busy = 0, m_pend = 0, m_go_cnt = -1, m_hi = 0;
    bit  m_ready = 0, m_prev_go = 0, m_hi_pend = 0;

    typedef logic [16:0] exp_t;
    exp_t  exp_q[$];
    int    n_cmp = 0, n_bad = 0;
    string phase = "reset";

    function automatic int clampn(input int v);
        return (v > 9) ? 9 : v;
    endfunction

    function automatic exp_t expect_now();
        int d4, d3, d2, d1, page, v;
        page = (m_go_cnt < 0) ? 1 : (m_go_cnt / ALT) % NPAGES;
        v = (page == 2) ? m_hi : m_score;
        d4 = v / 1000; d3 = (v / 100) % 10; d2 = (v / 10) % 10; d1 = v % 10;
        if (page == 0) begin d4 = 12; d3 = 13; d2 = 14; d1 = 15; end
        if (page == 2 && d4 == 0) d4 = 11;
        return {d4[3:0], d3[3:0], d2[3:0], d1[3:0], m_ready};
    endfunction

    task automatic model_edge();
        bit hs, rise;
        if (rst) begin
            m_score = 0; m_busy = 0; m_ready = 0; m_go_cnt = -1;
            m_hi = 0; m_hi_pend = 0; m_prev_go = 0;
        end else if (new_game) begin
            m_score = 0; m_busy = 0; m_hi_pend = 0;
            m_ready = !game_over; m_go_cnt = -1; m_prev_go = game_over;
        end else begin
            hs   = add_valid && m_ready;
            rise = game_over && !m_prev_go;
            if (rise) begin
                if (m_busy > 0) m_hi_pend = 1;
                else if (m_score > m_hi) m_hi = m_score;
            end
            if (m_busy > 0) begin
                m_busy--;
                if (m_busy == 0) begin
                    m_score = (m_score + m_pend > 9999) ? 9999 : m_score + m_pend;
                    if (m_hi_pend) begin
                        if (m_score > m_hi) m_hi = m_score;
                        m_hi_pend = 0;
                    end
                end
            end else if (hs) begin
                m_pend = clampn(int'(add_pts[7:4])) * 10 + clampn(int'(add_pts[3:0]));
                m_busy = 4;
            end
            m_ready   = (m_busy == 0) && !game_over;
            m_go_cnt  = game_over ? ((m_go_cnt < 0) ? 0 : m_go_cnt + 1) : -1;
            m_prev_go = game_over;
        end
    endtask

    task automatic cyc(input bit r, input bit ng, input bit go, input bit v, input logic [7:0] p);
        @(negedge clk);
        rst = r; new_game = ng; game_over = go; add_valid = v; add_pts = p;
        @(posedge clk);
        model_edge();
        exp_q.push_back(expect_now());
    endtask

    task automatic idle(input int n, input bit go);
        for (int i = 0; i < n; i++) cyc(0, 0, go, 0, 8'h00);
    endtask

    task automatic award(input logic [7:0] p);
        int guard = 0;
        while (!m_ready && guard < 20) begin
            cyc(0, 0, 0, 0, 8'h00);
            guard++;
        end
        if (!m_ready) begin
            n_bad++;
            $display("FAIL %s award_wait: ready never expected within 20 cycles", phase);
        end
        cyc(0, 0, 0, 1, p);
    endtask

    task automatic game_over_phase(input int n);
        cyc(0, 0, 1, 0, 8'h00);
        for (int i = 1; i < n; i++) cyc(0, 0, 1, $urandom_range(0, 1), 8'($urandom));
        idle(3, 0);
    endtask

    // Monitor: one expected display/ready word per clock edge.
    always @(negedge clk) begin
        exp_t e, got;
        if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            got = {score_4, score_3, score_2, score_1, add_ready};
            n_cmp++;
            if (got !== e) begin
                n_bad++;
                $display("FAIL %s t=%0t: got digits %0d,%0d,%0d,%0d ready %0b, required %0d,%0d,%0d,%0d ready %0b",
                         phase, $time, got[16:13], got[12:9], got[8:5], got[4:1], got[0],
                         e[16:13], e[12:9], e[8:5], e[4:1], e[0]);
            end
        end
    end

    initial begin
        bit go_lvl, ng, v;
        cyc(1, 0, 0, 0, 8'h00);
        cyc(1, 0, 0, 0, 8'h00);
        idle(2, 0);

        phase = "award25";
        award(8'h25);
        idle(6, 0);

        phase = "carry";
        cyc(0, 1, 0, 0, 8'h00);
        for (int i = 0; i < 10; i++) award(8'h99);
        award(8'h05);
        award(8'h07);
        idle(6, 0);

        phase = "saturate";
        cyc(0, 1, 0, 0, 8'h00);
        for (int i = 0; i < 100; i++) award(8'h99);
        award(8'h90);
        award(8'h25);
        award(8'h01);
        award(8'hFF);
        idle(6, 0);

        phase = "gameover";
        cyc(0, 1, 0, 0, 8'h00);
        award(8'h42);
        idle(6, 0);
        game_over_phase(20);

        phase = "abort";
        award(8'h33);
        idle(1, 0);
        cyc(0, 1, 0, 0, 8'h00);
        idle(6, 0);
        award(8'h12);
        idle(6, 0);
        cyc(1, 1, 0, 0, 8'h00);
        idle(3, 0);

        phase = "hiscore";
        cyc(0, 1, 0, 0, 8'h00);
        award(8'h99);
        award(8'h51);
        idle(5, 0);
        game_over_phase(12);
        cyc(0, 1, 0, 0, 8'h00);
        award(8'h30);
        idle(5, 0);
        game_over_phase(14);

        phase = "random";
        go_lvl = 0;
        for (int i = 0; i < 400; i++) begin
            bit rise;
            rise = 0;
            if ($urandom_range(0, 29) == 0) begin
                rise   = !go_lvl;
                go_lvl = !go_lvl;
            end
            ng = !rise && ($urandom_range(0, 39) == 0);
            v  = !rise && ($urandom_range(0, 1) == 1);
            cyc(0, ng, go_lvl, v, 8'($urandom));
        end
        idle(3, 0);

        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/score_display_ctrl.md
Name: score_display_ctrl

Overview:
- Owns the 4-digit BCD game score and decides what the 4-digit seven-segment display shows.
- Accepts point awards through a valid/ready handshake and adds them serially, one BCD digit per cycle, saturating at 9999.
- On game over, alternates the display between the "OVER" glyphs and the score.
- Outputs score_1..score_4 drive the seven-segment multiplexer directly.

Parameters:
- ALT_CYCLES, 50_000_000, clk cycles each page is shown during game-over alternation (1 s at 50 MHz); must be >= 2.
- CNT_W, 26, width of the alternation timer; must hold ALT_CYCLES-1.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- new_game  in  1  one-cycle pulse; clears the score and returns to play display
- game_over  in  1  level; high while the game is over
- add_valid  in  1  point award request
- add_pts  in  8  award as 2 BCD digits: [7:4] tens, [3:0] ones
- add_ready  out  1  award accepted on a cycle where add_valid and add_ready are both high
- score_1  out  4  display code, ones position (rightmost)
- score_2  out  4  display code, tens position
- score_3  out  4  display code, hundreds position
- score_4  out  4  display code, thousands position (leftmost)

Behaviour:
- Display codes: 0-9 are digits; 11 is dash; 12 'O', 13 'V', 14 'E', 15 'R'.
- Reset (rst high at a clk edge):
  - score register = 0000.
  - Add FSM = IDLE; display FSM = PLAY.
  - Timer = 0.
  - Outputs: score_4..1 = 0,0,0,0 and add_ready = 0 in the reset cycle, then 1 from the next cycle.
- Add FSM states: IDLE, ADD (digit index k = 0..3).
  - IDLE: add_ready = !game_over. A handshake at edge T latches add_pts, sets k = 0, carry = 0, and enters ADD.
  - ADD: at edge T+1+k, working digit k = score[k] + pts[k] + carry, with pts[2] = pts[3] = 0.
  - If the digit sum > 9: subtract 10 and set carry. k increments.
  - add_ready = 0 throughout ADD.
  - At edge T+4 (k = 3): if carry-out, the result is forced to 9999. The working copy is committed to the score register in a single update, so outputs never show a partial sum. FSM returns to IDLE.
  - add_ready is high again from cycle T+5, or stays low if game_over is asserted.
  - Back-to-back awards therefore take 5 cycles each.
  - Invalid BCD in add_pts (a nibble > 9) is clamped to 9 at latch time.
- Display FSM states: PLAY, GO_OVER, GO_SCORE.
  - PLAY: outputs = score register. If game_over is high, go to GO_OVER and clear the timer.
  - GO_OVER: outputs = 12,13,14,15 on score_4..score_1.
  - GO_SCORE: outputs = score register.
  - In GO_OVER and GO_SCORE the timer counts 0..ALT_CYCLES-1. On the terminal count the FSM toggles GO_OVER <-> GO_SCORE and the timer wraps to 0.
  - game_over low while in GO_OVER or GO_SCORE: return to PLAY on the next edge.
- Simultaneous events:
  - Priority is rst > new_game > handshake.
  - new_game aborts an in-flight ADD (no commit) and forces score to 0000, Add FSM to IDLE, display to PLAY, and timer to 0. It applies even while game_over is high; display re-enters GO_OVER on the following cycle if game_over is still high.
  - game_over rising during ADD: the add completes and commits; no new handshake is accepted while game_over is high.
- All outputs are registered.

Optional Feature:
- Macro HIGH_SCORE_EN.
- Defined:
  - A 16-bit high-score register is cleared only by rst; new_game does not clear it.
  - On the rising edge of game_over, and after any in-flight add commits, hi = max(hi, score). A plain 16-bit unsigned compare is valid because BCD preserves ordering.
  - Alternation becomes a three-page cycle GO_OVER -> GO_SCORE -> GO_HI -> GO_OVER. GO_HI shows hi, with score_4 replaced by 11 (dash) when the hi thousands digit is 0.
- Undefined: two-page alternation only; no high-score register exists.

Decomposition:
- Package score_defs:
  - Display code constants CODE_DASH = 11, CODE_O = 12, CODE_V = 13, CODE_E = 14, CODE_R = 15.
  - Add FSM state encoding and display FSM state encoding.
- Sub-module bcd_digit_add: combinational; inputs a[3:0], b[3:0], cin; outputs sum[3:0], cout. It is instantiated once and reused serially across the four digits.

Test Plan:
- Reset then award 0x25 -> add_ready low for 4 cycles; outputs read 0,0,2,5 (score_4..1) at T+4; add_ready high at T+5.
- Score 0995 plus award 0x07 -> 1,0,0,2; carry propagates through all digits; no intermediate value ever appears on the outputs.
- Score 9990 plus award 0x25 -> saturates at 9,9,9,9; a further award 0x01 keeps 9999.
- With ALT_CYCLES = 4, score 0042, assert game_over -> next cycle shows 12,13,14,15 for 4 cycles, then 0,0,4,2 for 4 cycles, repeating. Deasserting game_over -> 0,0,4,2 next cycle. add_ready low while game_over is high.
- new_game pulsed at T+2 of an award in flight -> score 0000 with no commit, add_ready high next cycle; rst and new_game together behave as rst.
- HIGH_SCORE_EN defined, ALT_CYCLES = 4:
  - Game 1 ends at 0150.
  - new_game, award 0x30, end game 2 at 0030 -> pages cycle OVER / 0,0,3,0 / 11,1,5,0; hi stays 0150.
